// File: rtl/cpu_wb_pkg.sv
// Shared types and helpers for the writeback pipeline.
// The bundle type is sized for the largest supported configuration; narrower builds zero-extend.
package cpu_wb_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefRegW  = 5;
  localparam int unsigned DefNumCh = 1;

  localparam int unsigned MaxCh    = 4;
  localparam int unsigned MaxRegW  = 8;
  localparam int unsigned MaxDataW = 64;

  localparam logic [MaxRegW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [MaxCh-1:0]               en;
    logic [MaxCh-1:0][MaxRegW-1:0]  wr_reg;
    logic [MaxCh-1:0][MaxDataW-1:0] data;
  } wb_bundle_t;

  // Drop writes to the zero register, then let the highest-indexed channel win any
  // same-register conflict so the bundle matches program order.
  function automatic wb_bundle_t wb_sanitise(wb_bundle_t b);
    wb_bundle_t       s;
    logic [MaxCh-1:0] live;
    s = b;
    for (int k = 0; k < MaxCh; k++) begin
      live[k] = b.en[k] && (b.wr_reg[k] != ZERO_REG);
    end
    for (int j = 0; j < MaxCh; j++) begin
      s.en[j] = live[j];
      for (int k = 0; k < MaxCh; k++) begin
        if (k > j && live[k] && (b.wr_reg[k] == b.wr_reg[j])) begin
          s.en[j] = 1'b0;
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/cpu_wb_skid.sv
// Generic two-entry valid/ready skid buffer with flush and synchronous active-low reset.
// in_ready comes straight from the skid-entry flop, so out_ready never reaches it combinationally.
module cpu_wb_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;
  logic             main_free;

  assign in_ready_o  = rst_ni & ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  assign in_fire   = in_valid_i & in_ready_o;
  assign main_free = ~main_valid_q | out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      // Data flops keep their contents so out_write_reg/data hold their last values.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) begin
          main_data_d = in_data_i;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/cpu_writeback_pipe.sv
// Writeback pipeline register: sanitises write bundles and buffers them through a skid buffer.
// Optional retire counter enabled by defining CPU_WB_RETIRE_CNT_EN.
module cpu_writeback_pipe
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned REG_W  = DefRegW,
  parameter int unsigned NUM_CH = DefNumCh
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH-1:0]        in_write_en,
  input  logic [NUM_CH*REG_W-1:0]  in_write_reg,
  input  logic [NUM_CH*DATA_W-1:0] in_write_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        out_write_en,
  output logic [NUM_CH*REG_W-1:0]  out_write_reg,
  output logic [NUM_CH*DATA_W-1:0] out_write_data,
  output logic [31:0]              retire_count
);

  localparam int unsigned RegOff = NUM_CH * DATA_W;
  localparam int unsigned EnOff  = RegOff + NUM_CH * REG_W;
  localparam int unsigned PayW   = EnOff + NUM_CH;

  wb_bundle_t        raw_bundle;
  wb_bundle_t        clean_bundle;
  logic [PayW-1:0]   in_payload;
  logic [PayW-1:0]   out_payload;
  logic              unused_clean;

  always_comb begin
    raw_bundle = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      raw_bundle.en[k]                 = in_write_en[k];
      raw_bundle.wr_reg[k][REG_W-1:0]  = in_write_reg[k*REG_W +: REG_W];
      raw_bundle.data[k][DATA_W-1:0]   = in_write_data[k*DATA_W +: DATA_W];
    end
  end

  assign clean_bundle = wb_sanitise(raw_bundle);
  assign unused_clean = ^clean_bundle;

  always_comb begin
    in_payload = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      in_payload[k*DATA_W +: DATA_W]         = clean_bundle.data[k][DATA_W-1:0];
      in_payload[RegOff + k*REG_W +: REG_W]  = clean_bundle.wr_reg[k][REG_W-1:0];
      in_payload[EnOff + k]                  = clean_bundle.en[k];
    end
  end

  cpu_wb_skid #(
    .WIDTH(PayW)
  ) u_skid (
    .clk_i      (clock),
    .rst_ni     (reset),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_payload),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_payload)
  );

  assign out_write_data = out_payload[0 +: NUM_CH*DATA_W];
  assign out_write_reg  = out_payload[RegOff +: NUM_CH*REG_W];
  assign out_write_en   = out_payload[EnOff +: NUM_CH] & {NUM_CH{out_valid}};

`ifdef CPU_WB_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  // Flush never clears the count; a delivery on the flush edge still counts.
  always_comb begin
    retire_d = retire_q;
    if (out_valid && out_ready) begin
      retire_d = retire_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_cpu_writeback_pipe.sv
// Scoreboard bench for cpu_writeback_pipe in a dual-channel configuration.
module tb_cpu_writeback_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned NC = 2;
  localparam int unsigned BW = NC + NC * RW + NC * DW;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NC-1:0]    in_write_en = '0;
  logic [NC*RW-1:0] in_write_reg = '0;
  logic [NC*DW-1:0] in_write_data = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [NC-1:0]    out_write_en;
  logic [NC*RW-1:0] out_write_reg;
  logic [NC*DW-1:0] out_write_data;
  logic [31:0]      retire_count;

  logic [BW-1:0] sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [31:0]   delivered = '0;

  always #5 clock = ~clock;

  cpu_writeback_pipe #(
    .DATA_W(DW),
    .REG_W (RW),
    .NUM_CH(NC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_write_en   (in_write_en),
    .in_write_reg  (in_write_reg),
    .in_write_data (in_write_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_write_en  (out_write_en),
    .out_write_reg (out_write_reg),
    .out_write_data(out_write_data),
    .retire_count  (retire_count)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent model: a channel survives if enabled, non-zero, and no later live channel shares its reg.
  function automatic logic [BW-1:0] model(input logic [NC-1:0] en, input logic [NC*RW-1:0] r,
                                          input logic [NC*DW-1:0] d);
    logic [NC-1:0] e;
    for (int k = 0; k < NC; k++) begin
      e[k] = en[k] && (r[k*RW +: RW] != '0);
      for (int m = k + 1; m < NC; m++) begin
        if (en[m] && (r[m*RW +: RW] != '0) && (r[m*RW +: RW] == r[k*RW +: RW])) e[k] = 1'b0;
      end
    end
    return {e, r, d};
  endfunction

  function automatic logic [31:0] retire_exp();
`ifdef CPU_WB_RETIRE_CNT_EN
    return delivered;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [NC-1:0] en, input logic [RW-1:0] r0,
                       input logic [RW-1:0] r1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    in_valid      = v;
    in_write_en   = en;
    in_write_reg  = {r1, r0};
    in_write_data = {d1, d0};
  endtask

  // Book-keep handshakes at the falling edge, then advance past the rising edge.
  task automatic step();
    logic [BW-1:0] exp;
    @(negedge clock);
    if (!reset) begin
      sb.delete();
      delivered = '0;
    end else begin
      if (out_valid && out_ready) begin
        delivered++;
        if (sb.size() == 0) begin
          check_eq("out_unexpected", 128'(1), 128'(0));
        end else begin
          exp = sb.pop_front();
          check_eq("out_bundle", 128'({out_write_en, out_write_reg, out_write_data}), 128'(exp));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(in_write_en, in_write_reg, in_write_data));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [NC-1:0] san_en[4];
    logic [RW-1:0] san_r0[4];
    logic [RW-1:0] san_r1[4];
    logic [NC-1:0] san_exp[4];
    logic [RW-1:0] reg0;
    int            idx;
    logic          fire;

    san_en  = '{2'b11, 2'b11, 2'b01, 2'b11};
    san_r0  = '{5'd7, 5'd0, 5'd5, 5'd4};
    san_r1  = '{5'd7, 5'd3, 5'd5, 5'd9};
    san_exp = '{2'b10, 2'b10, 2'b01, 2'b11};

    // Reset
    #1;
    check_eq("reset_in_ready_low", 128'(in_ready), 128'(0));
    step();
    step();
    reset = 1'b1;
    step();
    check_eq("reset_out_valid", 128'(out_valid), 128'(0));
    check_eq("reset_out_en", 128'(out_write_en), 128'(0));
    check_eq("reset_out_reg", 128'(out_write_reg), 128'(0));
    check_eq("reset_retire", 128'(retire_count), 128'(0));
    check_eq("reset_in_ready", 128'(in_ready), 128'(1));

    // Streaming, zero bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b01, RW'(i + 1), '0, DW'(32'hA000 + i), '0);
      if (i > 0) begin
        reg0 = out_write_reg[RW-1:0];
        check_eq("stream_valid", 128'(out_valid), 128'(1));
        check_eq("stream_reg", 128'(reg0), 128'(i));
      end
      step();
    end
    drive(1'b0, '0, '0, '0, '0, '0);
    reg0 = out_write_reg[RW-1:0];
    check_eq("stream_last_reg", 128'(reg0), 128'(8));
    step();
    check_eq("stream_idle", 128'(out_valid), 128'(0));

    // Backpressure for three cycles mid-stream
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 6 || sb.size() != 0); cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      drive(idx < 6, 2'b01, RW'(idx + 10), '0, DW'(32'hB000 + idx), '0);
      if (cyc == 4) begin
        check_eq("bp_in_ready", 128'(in_ready), 128'(0));
        check_eq("bp_out_valid", 128'(out_valid), 128'(1));
      end
      fire = in_valid && in_ready;
      step();
      if (fire) idx++;
    end
    check_eq("bp_all_sent", 128'(idx), 128'(6));
    check_eq("bp_drained", 128'(sb.size()), 128'(0));

    // Sanitise
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, san_en[p], san_r0[p], san_r1[p], DW'(32'hC000 + p), DW'(32'hD000 + p));
      step();
      drive(1'b0, '0, '0, '0, '0, '0);
      check_eq("sanitise_en", 128'(out_write_en), 128'(san_exp[p]));
      step();
    end

    // Flush with main and skid full plus an incoming bundle
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 5'd20, '0, 32'hE000, '0);
    step();
    drive(1'b1, 2'b01, 5'd21, '0, 32'hE001, '0);
    step();
    check_eq("flush_pre_ready", 128'(in_ready), 128'(0));
    drive(1'b1, 2'b01, 5'd22, '0, 32'hE002, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0);
    check_eq("flush_out_valid", 128'(out_valid), 128'(0));
    check_eq("flush_in_ready", 128'(in_ready), 128'(1));
    check_eq("flush_out_en", 128'(out_write_en), 128'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("flush_no_ghost", 128'(out_valid), 128'(0));
    check_eq("retire_after_flush", 128'(retire_count), 128'(retire_exp()));

    // Random traffic with occasional flush
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_eq("rand_drained", 128'(sb.size()), 128'(0));
    check_eq("retire_count", 128'(retire_count), 128'(retire_exp()));

    // Reset while stalled with both entries full
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 5'd30, '0, 32'hF000, '0);
    step();
    drive(1'b1, 2'b01, 5'd31, '0, 32'hF001, '0);
    step();
    drive(1'b0, '0, '0, '0, '0, '0);
    check_eq("stall_full", 128'(in_ready), 128'(0));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("midreset_out_valid", 128'(out_valid), 128'(0));
    check_eq("midreset_retire", 128'(retire_count), 128'(0));
    step();
    check_eq("midreset_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("midreset_no_ghost", 128'(out_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_writeback_pipe.md
Name: cpu_writeback_pipe

Overview:
Parametrised writeback pipeline register between the memory stage and the register file.
- Carries NUM_CH write channels per bundle; NUM_CH=2 serves dual-issue.
- Adds a valid/ready handshake so the register file can stall the pipe.
- Contains a 2-entry skid buffer that decouples the upstream ready from the downstream ready, plus a flush input.
- Sanitises write requests: drops writes to register zero and resolves same-register conflicts inside a bundle.

Parameters:
DATA_W, 32, width of each write-data channel
REG_W, 5, width of each register index
NUM_CH, 1, write channels per bundle (1..4)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low; sampled on the rising edge of clock
in_valid  in  1  upstream bundle valid
in_ready  out  1  upstream may transfer
in_write_en  in  NUM_CH  per-channel write request
in_write_reg  in  NUM_CH*REG_W  per-channel destination; channel k at [k*REG_W +: REG_W]
in_write_data  in  NUM_CH*DATA_W  per-channel data; channel k at [k*DATA_W +: DATA_W]
flush  in  1  discard all buffered bundles
out_valid  out  1  bundle presented to register file
out_ready  in  1  register file accepts bundle
out_write_en  out  NUM_CH  sanitised write enables
out_write_reg  out  NUM_CH*REG_W  destinations
out_write_data  out  NUM_CH*DATA_W  data
retire_count  out  32  delivered-bundle count (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clock edge):
  - main and skid entries invalid; all out_* registers = 0; retire_count = 0.
  - in_ready is forced 0 while reset is low.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: an accepted bundle appears on out_* the next cycle if main is empty or draining; otherwise it is held in order.
- Storage: main entry drives out_*; skid entry holds one overflow bundle.
- in_ready = !skid_valid, i.e. from a register, with no combinational path from out_ready.
- Per-edge update of main/skid:
  - Main empty or draining, skid empty: an input bundle loads main.
  - Main full and not draining: an input bundle loads skid.
  - Main draining, skid full: skid moves to main; any new input must have been refused, since in_ready=0.
  - Never lose, duplicate or reorder a bundle.
- Sanitise at capture (before storing):
  - write_en[k] is cleared when write_reg[k]==0.
  - If channels j<k both enabled with equal reg, clear en[j]; the highest index wins (program order).
  - A bundle with all enables cleared still transfers as valid.
- out_valid=0 ⇒ out_write_en=0; out_write_reg and out_write_data hold their last values.
- flush:
  - The next edge invalidates main and skid; out_write_en=0.
  - An input accepted in the same cycle as flush is discarded.
  - An output transfer completing in the flush cycle is counted and not undone.
  - Flush has priority over all loads.
- Reset has priority over flush.
- Reset mid-stall discards both entries.

Optional Feature:
Macro CPU_WB_RETIRE_CNT_EN.
- Defined: 32-bit counter increments on every output transfer.
  - Wraps 0xFFFFFFFF→0.
  - Cleared only by reset, not by flush.
- Undefined: counter logic absent; retire_count tied to 0.

Decomposition:
- Package cpu_wb_pkg:
  - default DATA_W/REG_W/NUM_CH
  - ZERO_REG constant (0)
  - wb_bundle_t typedef (en, reg, data arrays)
  - function wb_sanitise(bundle) → bundle (zero-drop plus conflict resolve)
- Natural sub-module: cpu_wb_skid.
  - Generic 2-entry valid/ready skid buffer over a WIDTH-bit payload, with flush.
  - Instantiated once with the flattened bundle.

Test Plan:
- Reset: reset=0 for 2 cycles, then released → out_valid=0, out_write_en=0, retire_count=0, in_ready=1 one cycle after release.
- Streaming: NUM_CH=1, out_ready=1, 8 back-to-back bundles (reg=i+1, data=0xA000+i) → identical bundles on out_* each one cycle later; zero bubbles.
- Backpressure: out_ready=0 for 3 cycles during a stream → exactly 2 bundles buffered, in_ready=0 from the 3rd cycle; release → all delivered in order, none lost.
- Sanitise: NUM_CH=2, en=2'b11:
  - reg0=7, reg1=7 → out_write_en=2'b10.
  - reg0=0, reg1=3 → out_write_en=2'b10.
- Flush: flush with main and skid full plus in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed bundles never appear.
- Counter (CPU_WB_RETIRE_CNT_EN): preload 0xFFFFFFFE, deliver 3 bundles → retire_count=1; a flush leaves the value unchanged.
